// File: rtl/event_blinker.sv
//-----------------------------------------------------------------------------
// event_blinker
//
// Turns single-cycle events (for example a debounced button press) into
// human-visible LED flashes. Each event produces one flash of ON_TICKS display
// ticks, followed by a dark gap of GAP_TICKS ticks. Display ticks come from a
// divider of TICK_DIV clk cycles. The divider only runs while a flash or gap
// is in progress.
//
// Build option:
//   EVENT_BLINKER_QUEUE_EN  defined   -> Events arriving during a flash or gap
//                                        are queued in a saturating counter.
//                                        Each one is replayed as a further
//                                        flash after the current gap.
//   EVENT_BLINKER_QUEUE_EN  undefined -> Events arriving during a flash or gap
//                                        are dropped. pend_cnt stays at 0.
//
// Parameters:
//   TICK_DIV   clk cycles per display tick (>= 2)
//   ON_TICKS   ticks the LED is lit per flash (>= 1)
//   GAP_TICKS  ticks the LED is dark after each flash (>= 1)
//   PEND_W     width of the pending-event counter
//
// Ports:
//   clk       in   system clock; all state changes on its rising edge
//   rst_n     in   asynchronous active-low reset
//   ev_in     in   single-cycle event pulse, synchronous to clk
//   led_out   out  registered LED drive; high only while flashing
//   busy      out  registered; high whenever a flash or gap is in progress
//   pend_cnt  out  events queued behind the current flash
//   ovf       out  registered one-cycle pulse for each dropped event
//-----------------------------------------------------------------------------
module event_blinker #(
    parameter int TICK_DIV  = 25000,
    parameter int ON_TICKS  = 400,
    parameter int GAP_TICKS = 200,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    // Widths of the cycle divider and the per-state tick counter
    localparam int DIV_W    = $clog2(TICK_DIV);
    localparam int TCNT_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TCNT_W   = (TCNT_MAX > 1) ? $clog2(TCNT_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [TCNT_W-1:0] tcnt_q,  tcnt_d;
    logic              led_q;
    logic              busy_q;
    logic              ovf_q,   ovf_d;

    logic tick;
    logic on_done;
    logic gap_done;
    logic active;

`ifdef EVENT_BLINKER_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] pend_q, pend_d;
`endif

    // The divider is held at 0 in IDLE. TICK_DIV >= 2, so no tick fires there.
    assign tick     = (div_q == DIV_LAST);
    assign on_done  = (state_q == S_ON)  && tick && (tcnt_q == ON_LAST);
    assign gap_done = (state_q == S_GAP) && tick && (tcnt_q == GAP_LAST);
    assign active   = (state_q != S_IDLE);

    //-------------------------------------------------------------------------
    // Next-state, timing counters and pending queue
    //-------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tcnt_d  = tcnt_q;
        ovf_d   = 1'b0;
`ifdef EVENT_BLINKER_QUEUE_EN
        pend_d  = pend_q;
`endif

        // Normal advance inside ON/GAP. The state cases below override this
        // on entry to a new state and in IDLE.
        if (tick) begin
            div_d  = '0;
            tcnt_d = tcnt_q + TCNT_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                tcnt_d = '0;
                if (ev_in) begin
                    state_d = S_ON;
                end
            end

            S_ON: begin
                if (on_done) begin
                    state_d = S_GAP;
                    div_d   = '0;
                    tcnt_d  = '0;
                end
            end

            S_GAP: begin
                if (gap_done) begin
                    div_d  = '0;
                    tcnt_d = '0;
`ifdef EVENT_BLINKER_QUEUE_EN
                    // A queued event, or a fresh one arriving right now,
                    // starts the next flash without passing through IDLE.
                    if ((pend_q != '0) || ev_in) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                tcnt_d  = '0;
            end
        endcase

`ifdef EVENT_BLINKER_QUEUE_EN
        if (gap_done && (pend_q != '0)) begin
            // One queued event is consumed here. A coincident new event
            // replaces it (net zero), except at saturation: there the new
            // event is absorbed by the freed slot only after the decrement
            // lands, so the count still drops by one and nothing is reported.
            if (!(ev_in && (pend_q != PEND_MAX))) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end else if (gap_done) begin
            // Empty queue: a coincident event starts the next flash directly
            // and is never counted.
            pend_d = pend_q;
        end else if (active && ev_in) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end
`else
        if (active && ev_in) begin
            ovf_d = 1'b1;
        end
`endif
    end

    //-------------------------------------------------------------------------
    // State and output registers
    //-------------------------------------------------------------------------
    // led/busy are registered from the next state. This keeps them in step
    // with state_q on every cycle without a combinational output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tcnt_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            led_q   <= (state_d == S_ON);
            busy_q  <= (state_d != S_IDLE);
            ovf_q   <= ovf_d;
        end
    end

`ifdef EVENT_BLINKER_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_cnt = pend_q;
`else
    assign pend_cnt = '0;
`endif

    assign led_out = led_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_event_blinker.sv
module tb_event_blinker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ev_in;
    logic       ev_long;

    logic       led_out, busy, ovf;
    logic [3:0] pend_cnt;
    logic       led_l, busy_l, ovf_l;
    logic [3:0] pend_l;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Main instance: ON = 8 cycles, GAP = 4 cycles
    event_blinker #(
        .TICK_DIV (4),
        .ON_TICKS (2),
        .GAP_TICKS(1),
        .PEND_W   (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev_in   (ev_in),
        .led_out (led_out),
        .busy    (busy),
        .pend_cnt(pend_cnt),
        .ovf     (ovf)
    );

    // Long-flash instance: ON = 32 cycles, GAP = 4 cycles. 17 back-to-back
    // events therefore all land inside a single flash.
    event_blinker #(
        .TICK_DIV (4),
        .ON_TICKS (8),
        .GAP_TICKS(1),
        .PEND_W   (4)
    ) u_long (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev_in   (ev_long),
        .led_out (led_l),
        .busy    (busy_l),
        .pend_cnt(pend_l),
        .ovf     (ovf_l)
    );

    // Every scenario runs at "#1 after a rising edge".
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ev_in   = 1'b0;
        ev_long = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        ev_in   = 1'b0;
        ev_long = 1'b0;
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (led_out !== 1'b0) begin tests_failed++; $display("FAIL reset led_out got %b want 0", led_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy got %b want 0", busy); end
        tests_run++;
        if (pend_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset pend_cnt got %0d want 0", pend_cnt); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset ovf got %b want 0", ovf); end
        tests_run++;
        if ({led_l, busy_l, ovf_l, pend_l} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset long_dut got %b want 0000000", {led_l, busy_l, ovf_l, pend_l});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // One event after reset gives an 8-cycle flash and a 4-cycle gap.
    task automatic test_single_flash();
        logic exp_led, exp_busy;
        apply_reset();
        repeat (8) next_cycle();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            exp_led  = (r <= 8);
            exp_busy = (r <= 12);
            tests_run++;
            if (led_out !== exp_led) begin tests_failed++; $display("FAIL single_flash led r=%0d got %b want %b", r, led_out, exp_led); end
            tests_run++;
            if (busy !== exp_busy) begin tests_failed++; $display("FAIL single_flash busy r=%0d got %b want %b", r, busy, exp_busy); end
            tests_run++;
            if ({ovf, pend_cnt} !== 5'd0) begin tests_failed++; $display("FAIL single_flash ovf/pend r=%0d got %b want 00000", r, {ovf, pend_cnt}); end
            next_cycle();
        end
    endtask

    // A mid-flash reset clears outputs at once; the next event gives a full flash.
    task automatic test_reset_mid_flash();
        logic exp_led, exp_busy;
        apply_reset();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        repeat (3) next_cycle();
        tests_run++;
        if (led_out !== 1'b1) begin tests_failed++; $display("FAIL mid_reset pre led got %b want 1", led_out); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (led_out !== 1'b0) begin tests_failed++; $display("FAIL mid_reset async led got %b want 0", led_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset async busy got %b want 0", busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        for (int r = 1; r <= 13; r++) begin
            exp_led  = (r <= 8);
            exp_busy = (r <= 12);
            tests_run++;
            if (led_out !== exp_led) begin tests_failed++; $display("FAIL mid_reset reflash led r=%0d got %b want %b", r, led_out, exp_led); end
            tests_run++;
            if (busy !== exp_busy) begin tests_failed++; $display("FAIL mid_reset reflash busy r=%0d got %b want %b", r, busy, exp_busy); end
            next_cycle();
        end
    endtask

`ifdef EVENT_BLINKER_QUEUE_EN
    // Events at relative cycles 0, 2, 4, 6 give four flashes.
    task automatic test_queue();
        logic       exp_led, exp_busy;
        logic [3:0] exp_pend;
        apply_reset();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        for (int r = 1; r <= 50; r++) begin
            exp_led  = (r <= 48) && (((r - 1) % 12) < 8);
            exp_busy = (r <= 48);
            if      (r <= 2)  exp_pend = 4'd0;
            else if (r <= 4)  exp_pend = 4'd1;
            else if (r <= 6)  exp_pend = 4'd2;
            else if (r <= 12) exp_pend = 4'd3;
            else if (r <= 24) exp_pend = 4'd2;
            else if (r <= 36) exp_pend = 4'd1;
            else              exp_pend = 4'd0;
            tests_run++;
            if (led_out !== exp_led) begin tests_failed++; $display("FAIL queue led r=%0d got %b want %b", r, led_out, exp_led); end
            tests_run++;
            if (busy !== exp_busy) begin tests_failed++; $display("FAIL queue busy r=%0d got %b want %b", r, busy, exp_busy); end
            tests_run++;
            if (pend_cnt !== exp_pend) begin tests_failed++; $display("FAIL queue pend r=%0d got %0d want %0d", r, pend_cnt, exp_pend); end
            ev_in = (r == 2) || (r == 4) || (r == 6);
            next_cycle();
        end
        ev_in = 1'b0;
    endtask

    // pend_cnt = 1 plus an event on the GAP-exit cycle: count stays at 1, next flash starts.
    task automatic test_gap_exit_event();
        apply_reset();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        for (int r = 1; r <= 13; r++) begin
            if (r == 12) begin
                tests_run++;
                if ({led_out, busy, pend_cnt} !== 6'b01_0001) begin
                    tests_failed++;
                    $display("FAIL gap_exit before led/busy/pend got %b want 010001", {led_out, busy, pend_cnt});
                end
            end
            if (r == 13) begin
                tests_run++;
                if (pend_cnt !== 4'd1) begin tests_failed++; $display("FAIL gap_exit pend got %0d want 1", pend_cnt); end
                tests_run++;
                if (led_out !== 1'b1) begin tests_failed++; $display("FAIL gap_exit led got %b want 1", led_out); end
                tests_run++;
                if (ovf !== 1'b0) begin tests_failed++; $display("FAIL gap_exit ovf got %b want 0", ovf); end
            end
            ev_in = (r == 2) || (r == 12);
            next_cycle();
        end
        ev_in = 1'b0;
    endtask

    // 17 back-to-back events fill the queue to 15 and overflow once. An event
    // on the saturated GAP exit drops the count to 14 with no ovf.
    task automatic test_saturation();
        logic [3:0] exp_pend;
        logic       exp_ovf;
        apply_reset();
        ev_long = 1'b1;
        next_cycle();
        for (int r = 1; r <= 37; r++) begin
            if (r <= 16)      exp_pend = 4'(r - 1);
            else if (r <= 36) exp_pend = 4'd15;
            else              exp_pend = 4'd14;
            exp_ovf = (r == 17);
            tests_run++;
            if (pend_l !== exp_pend) begin tests_failed++; $display("FAIL saturation pend r=%0d got %0d want %0d", r, pend_l, exp_pend); end
            tests_run++;
            if (ovf_l !== exp_ovf) begin tests_failed++; $display("FAIL saturation ovf r=%0d got %b want %b", r, ovf_l, exp_ovf); end
            if (r == 32 || r == 33 || r == 36 || r == 37) begin
                tests_run++;
                if (led_l !== ((r == 32) || (r == 37))) begin
                    tests_failed++;
                    $display("FAIL saturation led r=%0d got %b want %b", r, led_l, (r == 32) || (r == 37));
                end
            end
            ev_long = (r <= 16) || (r == 36);
            next_cycle();
        end
        ev_long = 1'b0;
    endtask
`else
    // Events during ON or GAP are dropped with one ovf pulse each. GAP still exits to IDLE.
    task automatic test_no_queue();
        logic exp_led, exp_busy, exp_ovf;
        apply_reset();
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            exp_led  = (r <= 8);
            exp_busy = (r <= 12);
            exp_ovf  = (r == 4) || (r == 11);
            tests_run++;
            if (led_out !== exp_led) begin tests_failed++; $display("FAIL no_queue led r=%0d got %b want %b", r, led_out, exp_led); end
            tests_run++;
            if (busy !== exp_busy) begin tests_failed++; $display("FAIL no_queue busy r=%0d got %b want %b", r, busy, exp_busy); end
            tests_run++;
            if (ovf !== exp_ovf) begin tests_failed++; $display("FAIL no_queue ovf r=%0d got %b want %b", r, ovf, exp_ovf); end
            tests_run++;
            if (pend_cnt !== 4'd0) begin tests_failed++; $display("FAIL no_queue pend r=%0d got %0d want 0", r, pend_cnt); end
            ev_in = (r == 3) || (r == 10);
            next_cycle();
        end
        ev_in = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_flash();
        test_reset_mid_flash();
`ifdef EVENT_BLINKER_QUEUE_EN
        test_queue();
        test_gap_exit_event();
        test_saturation();
`else
        test_no_queue();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/event_blinker.md
EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 Parameter TICK_DIV, default 25000: clk cycles per display tick (100 MHz -> 4 kHz tick); SHALL be >= 2.
REQ-002 Parameter ON_TICKS, default 400: ticks led_out is held high per flash (100 ms); SHALL be >= 1.
REQ-003 Parameter GAP_TICKS, default 200: ticks led_out is held low after each flash (50 ms); SHALL be >= 1.
REQ-004 Parameter PEND_W, default 4: width of the pending-event counter.
REQ-005 clk  input  1  system clock, all state on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ev_in  input  1  single-cycle event pulse, synchronous to clk, e.g. a debounced button press.
REQ-008 led_out  output  1  human-visible flash, registered.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 pend_cnt  output  PEND_W  events queued behind the current flash.
REQ-011 ovf  output  1  one-cycle pulse per dropped event.

Function
REQ-012 FSM states SHALL be IDLE, ON, GAP; led_out SHALL be 1 only in ON.
REQ-013 Tick divider SHALL count 0..TICK_DIV-1, be cleared on every entry to ON or GAP, and be held at 0 in IDLE; tick asserts when divider = TICK_DIV-1.
REQ-014 IDLE with ev_in=1: next cycle state ON, led_out=1 (1-cycle latency); this event SHALL NOT increment pend_cnt.
REQ-015 ON SHALL last exactly ON_TICKS*TICK_DIV cycles, then go to GAP.
REQ-016 GAP SHALL last exactly GAP_TICKS*TICK_DIV cycles, then go to ON when pend_cnt > 0 (pend_cnt decremented the same cycle), else go to IDLE.
REQ-017 ev_in in ON or GAP: pend_cnt SHALL increment by 1, saturating at 2^PEND_W-1.
REQ-018 ev_in at saturation SHALL leave pend_cnt unchanged and pulse ovf for one cycle, registered, on the next cycle.
REQ-019 ev_in coincident with the GAP-exit decrement SHALL leave pend_cnt unchanged (net +1-1); at saturation it SHALL decrement to 2^PEND_W-2 and SHALL NOT assert ovf.
REQ-020 busy SHALL be registered and consistent with state in the same cycle as led_out.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, led_out=0, busy=0, pend_cnt=0, ovf=0 and divider/tick count 0, including mid-flash; the first event after release SHALL start a full-length flash.

Configuration
REQ-022 Macro EVENT_BLINKER_QUEUE_EN defined: pending queue behaves per REQ-016..REQ-019.
REQ-023 Macro undefined: pend_cnt tied to 0; every ev_in in ON or GAP is dropped with a one-cycle ovf pulse; GAP always exits to IDLE.

Verification (TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1, PEND_W=4: ON = 8 cycles, GAP = 4 cycles)
REQ-024 Reset, then ev_in at cycle 10 -> led_out=1 cycles 11-18; busy=1 cycles 11-22; IDLE at cycle 23.
REQ-025 With QUEUE_EN: ev_in at cycles 10, 12, 14, 16 -> pend_cnt=3 at cycle 17; four 8-cycle flashes separated by 4-cycle gaps; pend_cnt decrements at each GAP exit; IDLE after the fourth gap.
REQ-026 With QUEUE_EN: 17 consecutive ev_in pulses starting in IDLE -> pend_cnt=15; exactly one ovf pulse, on the cycle after the 17th event.
REQ-027 With QUEUE_EN: pend_cnt=1 and ev_in on the GAP-exit cycle -> pend_cnt stays 1; state ON next cycle.
REQ-028 rst_n low for 1 cycle at cycle 14 of a flash -> led_out=0 and busy=0 without waiting for clk; next ev_in yields a full 8-cycle flash.
REQ-029 Without QUEUE_EN: ev_in at cycles 10 and 13 -> single flash cycles 11-18; ovf=1 at cycle 14 only; pend_cnt=0 throughout.
